serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, meaning the parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL provide parameter MSB_FIRST, default 1, meaning that the first serial bit of a word lands in par_out[WIDTH-1]; when 0, the first bit lands in par_out[0].
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 s_in  input  1  serial data from the upstream shift stage (its S_out).
REQ-006 shift_en  input  1  bit strobe; s_in is sampled only on edges where shift_en=1.
REQ-007 frame_start  input  1  resynchronisation; discards any partial word.
REQ-008 out_ready  input  1  downstream consumer can accept par_out.
REQ-009 ovr_clr  input  1  clears the sticky overrun flag.
REQ-010 par_out  output  WIDTH  assembled word, registered.
REQ-011 out_valid  output  1  par_out holds an unconsumed word.
REQ-012 overrun  output  1  sticky flag: a completed word was dropped.
REQ-013 bit_cnt  output  clog2(WIDTH)  number of bits collected in the current partial word.

Function
REQ-014 Internal shift register sreg (WIDTH bits), sampled only when shift_en=1: MSB_FIRST=1 -> sreg <= {sreg[WIDTH-2:0], s_in}; MSB_FIRST=0 -> sreg <= {s_in, sreg[WIDTH-1:1]}.
REQ-015 bit_cnt SHALL increment by 1 on each shift_en edge and wrap from WIDTH-1 to 0; it SHALL hold when shift_en=0.
REQ-016 Word completion SHALL be defined as shift_en=1 with bit_cnt=WIDTH-1; the completed word SHALL include the s_in sampled on that edge.
REQ-017 Output buffer FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 EMPTY + completion -> par_out loaded with the completed word and state moves to FULL on the same edge; out_valid is visible 1 cycle after the last bit is sampled.
REQ-019 FULL + out_ready=1 + no completion -> EMPTY; par_out SHALL retain its value (don't-care downstream).
REQ-020 FULL + out_ready=1 + completion -> old word consumed, new word loaded, state stays FULL; no bubble cycle.
REQ-021 FULL + out_ready=0 + completion -> new word dropped, par_out unchanged, state stays FULL, overrun set to 1.
REQ-022 While FULL and not accepted, par_out SHALL remain stable.
REQ-023 frame_start=1 SHALL clear bit_cnt and discard the partial word; if shift_en=1 on the same edge, that s_in SHALL become bit 0 of the new word (bit_cnt becomes 1).
REQ-024 frame_start=1 SHALL suppress completion on that edge, even when bit_cnt=WIDTH-1.
REQ-025 frame_start SHALL NOT affect out_valid, par_out or overrun.
REQ-026 overrun SHALL be cleared by ovr_clr=1; if set and clear coincide, set SHALL win.
REQ-027 Inputs in X state SHALL not be sampled when the corresponding enable is 0.

Reset
REQ-028 On a clk edge with rst_n=0: sreg=0, bit_cnt=0, par_out=0, out_valid=0, overrun=0, FSM=EMPTY.
REQ-029 Reset SHALL take priority over all other inputs, including mid-word and while FULL; the partial word and buffered word are discarded.
REQ-030 The first shift_en edge after rst_n returns high SHALL be sampled as bit 0 of a word.

Verification (WIDTH=8 unless stated)
REQ-031 MSB_FIRST=1: feed bits 1,0,1,0,0,1,0,1 with shift_en=1 and out_ready=1 -> par_out=8'hA5 and out_valid=1 for exactly one cycle, starting the cycle after the 8th bit.
REQ-032 MSB_FIRST=0: same bit stream -> par_out=8'hA5 reversed, i.e. 8'hA5 with LSB first gives 8'hA5 -> check 8'b10100101 mapped to par_out=8'hA5 bit-reversed = 8'hA5; use stream 1,1,1,1,0,0,0,0 -> par_out=8'h0F.
REQ-033 Two back-to-back words 8'h3C, 8'hC3 with out_ready=0 throughout -> par_out stays 8'h3C, out_valid=1, overrun=1; after ovr_clr pulse -> overrun=0.
REQ-034 Word 8'h11 held FULL, then out_ready=1 on the completion edge of 8'h22 -> the cycle after shows par_out=8'h22 with out_valid continuously 1 and overrun=0.
REQ-035 After 5 bits, frame_start=1 with shift_en=1 and s_in=1 -> bit_cnt=1; 7 more bits 0 -> par_out=8'h80.
REQ-036 rst_n=0 after 4 bits with out_valid=1 -> next cycle all outputs 0; 8 new bits then produce a correct word.

Source files
------------

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - serial-to-parallel word assembler with a one-word output buffer
// Collects shift_en-strobed bits into WIDTH-bit words and holds one completed word for a ready/valid consumer.

module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_in,
  input  logic                     shift_en,
  input  logic                     frame_start,
  input  logic                     out_ready,
  input  logic                     ovr_clr,
  output logic [WIDTH-1:0]         par_out,
  output logic                     out_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_par_out;
  logic             r_out_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sreg_base;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;

  // A frame_start discards the partial word, so the new bit shifts into an empty register.
  assign w_sreg_base = frame_start ? '0 : r_sreg;

  always_comb begin
    w_word = w_sreg_base;
    if (MSB_FIRST) begin
      w_word = {w_sreg_base[WIDTH-2:0], s_in};
    end else begin
      w_word = {s_in, w_sreg_base[WIDTH-1:1]};
    end
  end

  assign w_complete = shift_en && !frame_start && (r_bit_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (shift_en) begin
      r_sreg <= w_word;
      if (frame_start || (r_bit_cnt == LAST_IDX)) begin
        r_bit_cnt <= frame_start ? CW'(1) : '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end else if (frame_start) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end
  end

  // Output buffer: a completion while FULL and unaccepted is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_par_out   <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_complete) begin
            r_par_out   <= w_word;
            r_state     <= S_FULL;
            r_out_valid <= 1'b1;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            if (w_complete) begin
              r_par_out <= w_word;
            end else begin
              r_state     <= S_EMPTY;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase

      if ((r_state == S_FULL) && !out_ready && w_complete) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign par_out   = r_par_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - directed bench for serial_deserializer, MSB-first and LSB-first instances
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.

module tb_serial_deserializer;

  logic       clk;
  logic       rst_n;
  logic       s_in;
  logic       shift_en;
  logic       frame_start;
  logic       out_ready;
  logic       ovr_clr;

  logic [7:0] a_par, b_par;
  logic       a_valid, b_valid;
  logic       a_ovr, b_ovr;
  logic [2:0] a_cnt, b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .shift_en(shift_en),
    .frame_start(frame_start), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .par_out(a_par), .out_valid(a_valid), .overrun(a_ovr), .bit_cnt(a_cnt)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .shift_en(shift_en),
    .frame_start(frame_start), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .par_out(b_par), .out_valid(b_valid), .overrun(b_ovr), .bit_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic b);
    shift_en = 1'b1;
    s_in     = b;
    step();
  endtask

  // Sends the top n bits of w, most significant first.
  task automatic feed(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      send(w[7-i]);
    end
  endtask

  task automatic idle(input int n);
    shift_en = 1'b0;
    s_in     = 1'($urandom_range(0, 1));
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0; s_in = 1'b0; shift_en = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; ovr_clr = 1'b0;
    step();
    step();
    check("rst_par",   a_par,   32'h00);
    check("rst_valid", a_valid, 32'h0);
    check("rst_ovr",   a_ovr,   32'h0);
    check("rst_cnt",   a_cnt,   32'h0);
    check("rst_par_b", b_par,   32'h00);
    rst_n = 1'b1;
    idle(1);

    out_ready = 1'b1;
    feed(8'hA5, 7);
    check("a5_valid_pre", a_valid, 32'h0);
    check("a5_cnt_pre",   a_cnt,   32'h7);
    send(1'b1);
    check("a5_par",    a_par,   32'hA5);
    check("a5_valid",  a_valid, 32'h1);
    check("a5_cnt",    a_cnt,   32'h0);
    check("a5_par_b",  b_par,   32'hA5);
    check("a5_valid_b", b_valid, 32'h1);
    idle(1);
    check("a5_valid_drop", a_valid, 32'h0);
    check("a5_par_hold",   a_par,   32'hA5);

    feed(8'hF0, 8);
    check("f0_par",   a_par, 32'hF0);
    check("f0_par_b", b_par, 32'h0F);
    idle(1);

    out_ready = 1'b0;
    feed(8'h3C, 8);
    check("3c_par",   a_par,   32'h3C);
    check("3c_valid", a_valid, 32'h1);
    check("3c_ovr",   a_ovr,   32'h0);
    feed(8'hC3, 8);
    check("c3_par_hold", a_par,   32'h3C);
    check("c3_valid",    a_valid, 32'h1);
    check("c3_ovr",      a_ovr,   32'h1);
    check("c3_ovr_b",    b_ovr,   32'h1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("ovr_clr",       a_ovr,   32'h0);
    check("ovr_clr_valid", a_valid, 32'h1);
    feed(8'hFF, 7);
    ovr_clr = 1'b1;
    send(1'b1);
    ovr_clr = 1'b0;
    check("ovr_set_wins", a_ovr, 32'h1);
    check("ovr_par_hold", a_par, 32'h3C);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("ovr_clr2", a_ovr, 32'h0);
    out_ready = 1'b1;
    idle(1);
    check("drain_valid", a_valid, 32'h0);

    out_ready = 1'b0;
    feed(8'h11, 8);
    check("11_par",   a_par,   32'h11);
    check("11_valid", a_valid, 32'h1);
    feed(8'h22, 7);
    check("22_pre_valid", a_valid, 32'h1);
    check("22_pre_par",   a_par,   32'h11);
    out_ready = 1'b1;
    send(1'b0);
    check("22_par",   a_par,   32'h22);
    check("22_valid", a_valid, 32'h1);
    check("22_ovr",   a_ovr,   32'h0);
    idle(1);
    check("22_drain", a_valid, 32'h0);

    feed(8'hF8, 5);
    check("fs_cnt5", a_cnt, 32'h5);
    frame_start = 1'b1;
    send(1'b1);
    frame_start = 1'b0;
    check("fs_cnt1", a_cnt, 32'h1);
    feed(8'h00, 7);
    check("fs_par",   a_par,   32'h80);
    check("fs_valid", a_valid, 32'h1);
    check("fs_par_b", b_par,   32'h01);
    idle(1);

    feed(8'hFF, 7);
    check("fs7_cnt", a_cnt, 32'h7);
    frame_start = 1'b1;
    send(1'b1);
    frame_start = 1'b0;
    check("fs7_no_complete", a_valid, 32'h0);
    check("fs7_cnt1",        a_cnt,   32'h1);
    check("fs7_par_hold",    a_par,   32'h80);
    feed(8'h82, 7);
    check("fs7_par",   a_par, 32'hC1);
    check("fs7_par_b", b_par, 32'h83);
    idle(1);

    out_ready = 1'b0;
    feed(8'h99, 8);
    check("pre_rst_valid", a_valid, 32'h1);
    feed(8'hFF, 4);
    check("pre_rst_cnt", a_cnt, 32'h4);
    rst_n    = 1'b0;
    shift_en = 1'b1;
    s_in     = 1'b1;
    step();
    rst_n    = 1'b1;
    shift_en = 1'b0;
    check("mid_rst_par",   a_par,   32'h00);
    check("mid_rst_valid", a_valid, 32'h0);
    check("mid_rst_ovr",   a_ovr,   32'h0);
    check("mid_rst_cnt",   a_cnt,   32'h0);
    check("mid_rst_par_b", b_par,   32'h00);
    out_ready = 1'b1;
    feed(8'h5A, 8);
    check("post_rst_par",   a_par,   32'h5A);
    check("post_rst_valid", a_valid, 32'h1);
    check("post_rst_par_b", b_par,   32'h5A);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
